lfsr_seq_ctrl: RTL
==================

Name: lfsr_seq_ctrl

Overview:
Sequencer that owns the 4-bit LFSR's load port (sel/seed) and turns its free-running output into a counted, flow-controlled sample stream.
A requester issues start with a seed and a sample count. The controller loads the LFSR, then emits exactly that many samples over a valid/ready interface. It stalls the LFSR on back-pressure by reloading the current value.
Sits between the LFSR instance and any consumer, such as a test-pattern or scrambler stage.

Parameters:
WIDTH, 4, LFSR state width; must match the connected LFSR
CNT_W, 8, width of the sample-count request and the internal remaining counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
start_seed  input  WIDTH  seed for the request
start_count  input  CNT_W  number of samples to emit
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of request
err_zero_seed  output  1  one-cycle pulse: request rejected, seed was all-zero
lfsr_sel  output  1  to LFSR sel: 1 = load lfsr_seed at the next edge, 0 = shift
lfsr_seed  output  WIDTH  to LFSR seed
lfsr_w  input  WIDTH  LFSR current state (registered inside the LFSR)
out_data  output  WIDTH  sample; equals lfsr_w while out_valid
out_valid  output  1  sample available
out_ready  input  1  consumer accepts the sample
out_wrap  output  1  qualifies out_data: sample equals the seed and is not the first sample (period completed)

Behaviour:
- Connected LFSR: loads seed at an edge when sel=1, otherwise shifts once per edge. It is maximal length (period 2^WIDTH-1). It locks up on all-zero.
- States: IDLE, LOAD, RUN, DONE. Registers: seed_q, remaining (CNT_W), first_q.
- Reset (any state, mid-run included): next state IDLE. busy=0, done=0, err_zero_seed=0, out_valid=0, out_wrap=0, lfsr_sel=0, lfsr_seed=0, out_data=0, remaining=0, seed_q=0.
- IDLE: lfsr_sel=0, out_valid=0. On start:
  - start_seed==0 → err_zero_seed pulses the next cycle, state stays IDLE, no load.
  - else start_count==0 → DONE (done pulses the next cycle), no samples, no load.
  - else capture seed_q and remaining=start_count, set first_q=1, go to LOAD.
- LOAD (1 cycle): lfsr_sel=1, lfsr_seed=seed_q, out_valid=0. Next state RUN; lfsr_w==seed_q from the first RUN cycle.
- RUN: out_valid=1, out_data=lfsr_w. out_wrap=1 when lfsr_w==seed_q and first_q==0.
  - Handshake out_valid&out_ready: lfsr_sel=0 so the LFSR advances, remaining decrements, first_q clears. If remaining==1 at that point → DONE.
  - No handshake: lfsr_sel=1, lfsr_seed=lfsr_w (hold). out_data stays stable until accepted.
- lfsr_sel/lfsr_seed/out_valid/out_data in RUN are combinational from state and lfsr_w/out_ready. All state is registered.
- DONE (1 cycle): done=1, busy=1, out_valid=0, lfsr_sel=1, lfsr_seed=lfsr_w. Next state IDLE.
- start while busy: ignored, no queueing. done and err_zero_seed are never high together.
- Latency: start at edge N → first sample valid in cycle N+2. With out_ready held at 1, done occurs in cycle N+2+count.
- remaining is an unsigned down-counter. It cannot underflow because RUN is never entered with remaining==0.

Optional Feature:
LFSR_SEQ_ABORT_EN
- With it defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort in LOAD or RUN → DONE next cycle; done and aborted pulse together.
  - A sample whose handshake coincides with abort counts as consumed.
  - abort in IDLE or DONE is ignored.
- Without it: neither port exists; aborted behaviour is absent.

Test Plan:
- Reset mid-RUN (seed 4'b1111, count 10, after 3 samples) → next cycle IDLE, busy=0, out_valid=0, lfsr_sel=0; a new start then runs normally.
- start seed 4'b1111, count 16, out_ready=1 → 16 samples, sample1=sample16=4'b1111, out_wrap high only on sample 16, done 18 cycles after start.
- Same request with out_ready toggling 1,0,0,1 repeatedly → identical 16-value sequence, each stalled value held stable, lfsr_sel=1 on stall cycles.
- start seed 4'b0000 → err_zero_seed one cycle, busy stays 0, lfsr_sel never 1.
- start count 0 (seed 4'b1010) → done one cycle later, zero samples. Second start pulsed while busy is ignored (sample count unchanged).
- With LFSR_SEQ_ABORT_EN: seed 4'b0110, count 8, abort after 3 accepted samples → done=aborted=1 next cycle, exactly 3 samples.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: drives the load port of a connected WIDTH-bit LFSR and turns
// its free-running state into a counted sample stream over valid/ready.
// The LFSR is stalled on back-pressure by reloading its own current value.
// Optional build macro: LFSR_SEQ_ABORT_EN adds the abort input and the
// aborted output (early termination of a request from LOAD or RUN).
module lfsr_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] start_seed,
   input  logic [CNT_W-1:0] start_count,
   output logic             busy,
   output logic             done,
   output logic             err_zero_seed,
   output logic             lfsr_sel,
   output logic [WIDTH-1:0] lfsr_seed,
   input  logic [WIDTH-1:0] lfsr_w,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_wrap
`ifdef LFSR_SEQ_ABORT_EN
   ,
   input  logic             abort,
   output logic             aborted
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             first_q, first_d;
   logic             err_q, err_d;
   logic             aborted_q, aborted_d;
   logic             abort_req;
   logic             handshake;

`ifdef LFSR_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // A sample is consumed on any cycle the stream is offered and accepted.
   assign handshake = (state_q == RUN) && out_ready;

   // State and request registers; reset returns everything to an empty IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         seed_q      <= '0;
         remaining_q <= '0;
         first_q     <= 1'b0;
         err_q       <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         remaining_q <= remaining_d;
         first_q     <= first_d;
         err_q       <= err_d;
         aborted_q   <= aborted_d;
      end
   end

   // Next-state logic: request acceptance, sample counting and termination.
   always_comb begin
      state_d     = state_q;
      seed_d      = seed_q;
      remaining_d = remaining_q;
      first_d     = first_q;
      err_d       = 1'b0;
      aborted_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (start_seed == '0) begin
                  // An all-zero seed would lock the LFSR up; reject it.
                  err_d = 1'b1;
               end else if (start_count == '0) begin
                  // Nothing to emit: finish without touching the LFSR.
                  state_d = DONE;
               end else begin
                  seed_d      = start_seed;
                  remaining_d = start_count;
                  first_d     = 1'b1;
                  state_d     = LOAD;
               end
            end
         end

         LOAD: begin
            state_d = RUN;
            if (abort_req) begin
               state_d   = DONE;
               aborted_d = 1'b1;
            end
         end

         RUN: begin
            if (handshake) begin
               // remaining is never zero here, so the decrement cannot wrap.
               remaining_d = remaining_q - CNT_W'(1);
               first_d     = 1'b0;
               if (remaining_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
            // A sample accepted together with abort still counts as consumed.
            if (abort_req) begin
               state_d   = DONE;
               aborted_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from state; the RUN-state LFSR control follows out_ready
   // combinationally so a stalled sample is reloaded in the same cycle.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_wrap  = 1'b0;
      lfsr_sel  = 1'b0;
      lfsr_seed = '0;

      if (!reset) begin
         case (state_q)
            IDLE: begin
               busy = 1'b0;
            end

            LOAD: begin
               busy      = 1'b1;
               lfsr_sel  = 1'b1;
               lfsr_seed = seed_q;
            end

            RUN: begin
               busy      = 1'b1;
               out_valid = 1'b1;
               out_data  = lfsr_w;
               // Seeing the seed again after the first sample means the
               // LFSR has completed a full period.
               out_wrap  = (lfsr_w == seed_q) && !first_q;
               lfsr_sel  = !out_ready;
               lfsr_seed = lfsr_w;
            end

            DONE: begin
               busy      = 1'b1;
               done      = 1'b1;
               lfsr_sel  = 1'b1;
               lfsr_seed = lfsr_w;
            end

            default: begin
               busy = 1'b0;
            end
         endcase
      end
   end

   assign err_zero_seed = err_q && !reset;

`ifdef LFSR_SEQ_ABORT_EN
   assign aborted = aborted_q && (state_q == DONE) && !reset;
`else
   // Without the abort feature the flag can never be set.
   logic unused_aborted;
   assign unused_aborted = aborted_q;
`endif

endmodule
